// File: rtl/multdiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//   MD_WIDTH  : operand/result width (only 32 is supported)
//   MD_ITER   : iterations per operation, one bit per cycle
//   MD_CNT_W  : width of the iteration counter (wraps 31 -> 0)
//   state_e   : controller states
//   abs32     : two's complement magnitude (0x80000000 maps to 2^31 unsigned)
package multdiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = 32;
  localparam int MD_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/multdiv_cycle_cnt.sv
// Iteration counter for multdiv_seq.
//   clk   : clock
//   rs_n  : asynchronous active-low reset
//   clr_i : synchronous clear (start of an operation), has priority over en_i
//   en_i  : count enable (one step per cycle while iterating)
//   cnt_o : current count, wraps 31 -> 0
module multdiv_cycle_cnt
  import multdiv_pkg::*;
(
  input  logic                clk,
  input  logic                rs_n,
  input  logic                clr_i,
  input  logic                en_i,
  output logic [MD_CNT_W-1:0] cnt_o
);

  logic [MD_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/multdiv_seq.sv
// Sequential signed 32-bit multiplier / divider.
//   clk            : clock, all state changes on rising edge
//   rs_n           : asynchronous active-low reset
//   ctrl_MULT      : start a signed multiply (wins over ctrl_DIV)
//   ctrl_DIV       : start a signed divide (quotient only)
//   data_operandA  : multiplicand / dividend
//   data_operandB  : multiplier / divisor
//   data_result    : low 32 bits of product, or quotient
//   data_exception : product overflow, divide by zero, or 0x80000000 / -1
//   data_resultRDY : one-cycle completion pulse
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for a start pulse, outputs hold last result
// ST_MULT | one radix-2 Booth step per cycle, 32 steps
// ST_DIV  | one restoring-division quotient bit per cycle, 32 steps
// ST_DONE | sign fix / exception evaluation, result and RDY registered
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rs_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  state_e              state_q, state_d;
  // Multiply: {hi[64:33], lo[32:1], q-1[0]}; divide: {rem[64:32], quotient[31:0]}
  logic [64:0]         acc_q, acc_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic                is_div_q, is_div_d;
  logic [31:0]         result_q, result_d;
  logic                exc_q, exc_d;
  logic                rdy_q, rdy_d;

  logic [MD_CNT_W-1:0] cnt;
  logic                cnt_clr;
  logic                cnt_en;
  logic                last_step;

  multdiv_cycle_cnt u_cnt (
    .clk   (clk),
    .rs_n  (rs_n),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt)
  );

  assign last_step = (cnt == MD_CNT_W'(ITER - 1));

  // Booth step. The add is done at 33 bits so that hi -/+ 0x80000000 keeps
  // its true sign through the arithmetic shift.
  logic [32:0] booth_sum;
  logic [64:0] booth_next;

  always_comb begin
    booth_sum = {acc_q[64], acc_q[64:33]};
    case (acc_q[1:0])
      2'b01:   booth_sum = {acc_q[64], acc_q[64:33]} + {b_q[31], b_q};
      2'b10:   booth_sum = {acc_q[64], acc_q[64:33]} - {b_q[31], b_q};
      default: booth_sum = {acc_q[64], acc_q[64:33]};
    endcase
    booth_next = {booth_sum, acc_q[32:1]};
  end

  // Restoring division step on magnitudes.
  logic [31:0] b_mag;
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic        rem_ge;
  logic [64:0] div_next;

  always_comb begin
    b_mag     = abs32(b_q);
    rem_shift = {acc_q[63:32], acc_q[31]};
    rem_ge    = (rem_shift >= {1'b0, b_mag});
    rem_diff  = rem_shift - {1'b0, b_mag};
    div_next  = rem_ge ? {rem_diff, acc_q[30:0], 1'b1}
                       : {rem_shift, acc_q[30:0], 1'b0};
  end

  // Final result formatting.
  logic [31:0] quot_mag;
  logic [31:0] quot_signed;
  logic        mult_exc;
  logic        div_zero;
  logic        div_ovf;

  always_comb begin
    quot_mag    = acc_q[31:0];
    quot_signed = (a_q[31] ^ b_q[31]) ? (~quot_mag + 32'd1) : quot_mag;
    // product bits [63:31] live in acc_q[64:32]; they must all match
    mult_exc    = !((&acc_q[64:32]) || !(|acc_q[64:32]));
    div_zero    = (b_q == 32'd0);
    div_ovf     = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_MULT) begin
          a_d      = data_operandA;
          b_d      = data_operandB;
          acc_d    = {32'd0, data_operandA, 1'b0};
          is_div_d = 1'b0;
          cnt_clr  = 1'b1;
          state_d  = ST_MULT;
        end else if (ctrl_DIV) begin
          a_d      = data_operandA;
          b_d      = data_operandB;
          acc_d    = {33'd0, abs32(data_operandA)};
          is_div_d = 1'b1;
          cnt_clr  = 1'b1;
          state_d  = ST_DIV;
        end
      end
      ST_MULT: begin
        acc_d  = booth_next;
        cnt_en = 1'b1;
        if (last_step) state_d = ST_DONE;
      end
      ST_DIV: begin
        acc_d  = div_next;
        cnt_en = 1'b1;
        if (last_step) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (is_div_q) begin
          if (div_zero) begin
            result_d = 32'd0;
            exc_d    = 1'b1;
          end else begin
            result_d = quot_signed;
            exc_d    = div_ovf;
          end
        end else begin
          result_d = acc_q[32:1];
          exc_d    = mult_exc;
        end
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_seq.sv
module tb_multdiv_seq;

  logic        clk;
  logic        rs_n;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_last_res = '0;
  logic        exp_last_exc = 1'b0;

  multdiv_seq #(.WIDTH(32), .ITER(32)) dut (
    .clk            (clk),
    .rs_n           (rs_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic.
  task automatic model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic exc);
    longint p;
    int     lo, sa, sb;
    sa = a;
    sb = b;
    if (is_mult) begin
      p   = longint'(sa) * longint'(sb);
      lo  = int'(p[31:0]);
      res = p[31:0];
      exc = (p != longint'(lo));
    end else if (b == 32'd0) begin
      res = 32'd0;
      exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = 32'h8000_0000;
      exc = 1'b1;
    end else begin
      res = sa / sb;
      exc = 1'b0;
    end
  endtask

  // Called at #1 after a rising edge with the DUT idle. inj>0 pulses ctrl_DIV
  // with fresh operands so that it is sampled at edge E+inj.
  task automatic run_op(input string tag, input bit do_mult, input bit do_div,
                        input logic [31:0] a, input logic [31:0] b, input int inj);
    logic [31:0] exp_res, got_res;
    logic        exp_exc, got_exc;
    int          rdy_hits, rdy_at;
    bit          stable;
    model(do_mult, a, b, exp_res, exp_exc);
    ctrl_MULT     = do_mult;
    ctrl_DIV      = do_div;
    data_operandA = a;
    data_operandB = b;
    @(posedge clk);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    rdy_hits = 0;
    rdy_at   = 0;
    stable   = 1'b1;
    got_res  = '0;
    got_exc  = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk);
      #1;
      if (data_resultRDY === 1'b1) begin
        rdy_hits++;
        rdy_at = k;
      end
      if (k <= 32 && (data_result !== exp_last_res || data_exception !== exp_last_exc))
        stable = 1'b0;
      if (k == 33) begin
        got_res = data_result;
        got_exc = data_exception;
      end
      ctrl_DIV = 1'b0;
      if (inj > 0 && k == inj - 1) begin
        ctrl_DIV      = 1'b1;
        data_operandA = $urandom;
        data_operandB = $urandom;
      end
    end
    chk({tag, ".rdy_count"}, 64'(rdy_hits), 64'd1);
    chk({tag, ".rdy_edge"},  64'(rdy_at),   64'd33);
    chk({tag, ".stable"},    64'(stable),   64'd1);
    chk({tag, ".result"},    64'(got_res),  64'(exp_res));
    chk({tag, ".exc"},       64'(got_exc),  64'(exp_exc));
    exp_last_res = exp_res;
    exp_last_exc = exp_exc;
  endtask

  initial begin
    int rdy_hits;
    rs_n          = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #1;
    chk("rst.result", 64'(data_result),    64'd0);
    chk("rst.exc",    64'(data_exception), 64'd0);
    chk("rst.rdy",    64'(data_resultRDY), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rs_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("mul_7_m3",   1'b1, 1'b0, 32'd7,          32'hFFFF_FFFD, 0);
    run_op("mul_ovf",    1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000, 0);
    run_op("div_m100_7", 1'b0, 1'b1, 32'hFFFF_FF9C,  32'd7,         0);
    run_op("div_minm1",  1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 0);
    run_op("div_zero",   1'b0, 1'b1, 32'd5,          32'd0,         0);
    run_op("both_6_3",   1'b1, 1'b1, 32'd6,          32'd3,         10);
    run_op("mul_minmin", 1'b1, 1'b0, 32'h8000_0000,  32'h8000_0000, 0);
    run_op("div_byneg",  1'b0, 1'b1, 32'd100,        32'h8000_0000, 0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      bit          m;
      ra = $urandom;
      rb = $urandom;
      m  = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: rb = 32'($signed(rb) >>> $urandom_range(8, 30));
        1: ra = 32'($signed(ra) >>> $urandom_range(4, 28));
        2: if (!m && $urandom_range(0, 3) == 0) rb = 32'd0;
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), m, !m, ra, rb, 0);
    end

    // Abort an operation with reset, then check a clean restart.
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd123;
    data_operandB = 32'd456;
    @(posedge clk);
    #1;
    ctrl_MULT = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rs_n      = 1'b0;
    ctrl_MULT = 1'b1;
    #1;
    chk("midrst.result", 64'(data_result),    64'd0);
    chk("midrst.exc",    64'(data_exception), 64'd0);
    chk("midrst.rdy",    64'(data_resultRDY), 64'd0);
    rdy_hits = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (data_resultRDY === 1'b1 || data_result !== 32'd0) rdy_hits++;
    end
    ctrl_MULT = 1'b0;
    rs_n      = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (data_resultRDY === 1'b1) rdy_hits++;
    end
    chk("midrst.no_rdy", 64'(rdy_hits), 64'd0);
    exp_last_res = '0;
    exp_last_exc = 1'b0;
    run_op("post_rst_4x5", 1'b1, 1'b0, 32'd4, 32'd5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_seq.md
MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have parameter ITER, default 32, the iteration count, held in a 5-bit cycle counter that wraps 31->0.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rs_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ctrl_MULT  in  1  start pulse for a signed multiply.
REQ-006 SHALL have port ctrl_DIV  in  1  start pulse for a signed divide (quotient).
REQ-007 SHALL have port data_operandA  in  WIDTH  multiplicand / dividend, two's complement.
REQ-008 SHALL have port data_operandB  in  WIDTH  multiplier / divisor, two's complement.
REQ-009 SHALL have port data_result  out  WIDTH  low 32 bits of product, or quotient.
REQ-010 SHALL have port data_exception  out  1  overflow or divide-by-zero flag, valid with data_result.
REQ-011 SHALL have port data_resultRDY  out  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, MULT, DIV, DONE.
REQ-013 In IDLE, ctrl_MULT=1 SHALL capture both operands, clear the counter, and go to MULT. Otherwise ctrl_DIV=1 SHALL do the same and go to DIV.
REQ-014 If ctrl_MULT and ctrl_DIV are both 1 in IDLE, multiply SHALL win.
REQ-015 ctrl_MULT/ctrl_DIV asserted in MULT, DIV or DONE SHALL be ignored; operands captured at start SHALL be used throughout.
REQ-016 MULT SHALL perform radix-2 Booth, one step per cycle, on a 65-bit {hi,lo,q-1} register with arithmetic right shift.
REQ-017 DIV SHALL perform restoring division on operand magnitudes, one quotient bit per cycle. Quotient sign SHALL be A[31]^B[31], applied in DONE.
REQ-018 Counter SHALL increment each cycle in MULT/DIV. After the step taken at count 31, the FSM SHALL go to DONE.
REQ-019 Latency: if the start is sampled at edge E, iteration edges SHALL be E+1..E+32. data_resultRDY SHALL be 1 from edge E+33 to edge E+34, then the FSM returns to IDLE.
REQ-020 data_result and data_exception SHALL update at edge E+33. They SHALL hold until the next completion, stable while busy.
REQ-021 A start may be accepted at the edge following the RDY cycle (IDLE). Back-to-back operations SHALL therefore be spaced 34 cycles.
REQ-022 Multiply exception SHALL be 1 iff the 64-bit product's upper 33 bits are not all equal. data_result SHALL still be the low 32 bits.
REQ-023 Divide by zero (B=0) SHALL give data_result=0 and data_exception=1 with normal 33-cycle latency; no early exit.
REQ-024 Divide 0x80000000 / 0xFFFFFFFF SHALL give data_result=0x80000000 and data_exception=1.
REQ-025 Division SHALL truncate toward zero. The remainder SHALL be discarded.
REQ-026 Counter wrap from 31 to 0 SHALL coincide with the transition to DONE. No extra step SHALL occur.

Reset
REQ-027 rs_n=0 SHALL asynchronously set: FSM=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, all datapath registers 0.
REQ-028 Reset asserted mid-operation SHALL abort it with no RDY pulse. The first start after rs_n rises SHALL be accepted normally.
REQ-029 Outputs SHALL be held at reset values while rs_n=0, and ctrl inputs ignored.

Structure
REQ-030 Shared package multdiv_pkg SHALL hold the state enum, WIDTH=32, ITER=32, and the counter width 5.
REQ-031 The iteration counter SHALL be one sub-module, multdiv_cycle_cnt: 5-bit, synchronous clear on start, asynchronous rs_n, enable.
REQ-032 Booth and restoring datapaths SHALL be combinational logic inside multdiv_seq, sharing one 65-bit shift register.

Verification
REQ-033 Multiply: A=7, B=-3, ctrl_MULT pulse at edge E -> RDY high only between E+33 and E+34; result 0xFFFFFFEB; exception 0.
REQ-034 Multiply overflow: A=0x00010000, B=0x00010000 -> result 0x00000000; exception 1.
REQ-035 Divide: A=-100, B=7 -> result 0xFFFFFFF2 (-14); exception 0. Then A=0x80000000, B=-1 -> result 0x80000000; exception 1.
REQ-036 Divide by zero: A=5, B=0 -> RDY at E+33, result 0, exception 1.
REQ-037 Busy/simultaneous: ctrl_MULT+ctrl_DIV together with A=6, B=3 -> result 18 (multiply). A ctrl_DIV pulse with new operands at E+10 is ignored: result still 18, one RDY.
REQ-038 Reset mid-op: rs_n low at E+15 for 2 cycles -> outputs 0, no RDY. A new multiply 4*5 afterwards -> result 20 at its E'+33.
